// File: rtl/count_scheduler_pkg.sv
// Shared types and defaults for the count scheduler: FSM state encoding,
// default widths and an index-width helper.
package count_scheduler_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_NREQ  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Bits needed to hold a requester index; never less than one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/count_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after
// last_owner (wrapping) wins; valid flags that any request was present.
module rr_arbiter
    import count_scheduler_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int IDXW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_owner,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    // Scan from last_owner+1 upward; the first hit locks out later candidates.
    always_comb begin
        int   idx;
        logic hit;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        hit    = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx                 = (int'(last_owner) + i) % NREQ;
            hit                 = !valid && req[IDXW'(idx)];
            winner[IDXW'(idx)]  = winner[IDXW'(idx)] | hit;
            valid               = valid | hit;
        end
    end

endmodule

// File: rtl/count_scheduler.sv
// Shared-counter scheduler: grants one requester at a time, clears the
// counter, counts up to the owner's latched length, then reports done/abort.
module count_scheduler
    import count_scheduler_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NREQ  = DEFAULT_NREQ
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   len,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        count,
    output logic                    busy,
    output logic [NREQ-1:0]         done,
    output logic [NREQ-1:0]         abort
);

    localparam int IDXW = idx_width(NREQ);

    state_t            state_r;
    logic [IDXW-1:0]   owner_r;
    logic [IDXW-1:0]   last_owner_r;
    logic [WIDTH-1:0]  len_r;
    logic [WIDTH-1:0]  count_r;
    logic [NREQ-1:0]   gnt_r;
    logic [NREQ-1:0]   done_r;
    logic [NREQ-1:0]   abort_r;
    logic              busy_r;

    logic [NREQ-1:0]   win_s;
    logic              win_valid_s;
    logic [IDXW-1:0]   win_idx_s;
    logic [WIDTH-1:0]  win_len_s;
    logic              owner_req_s;
    logic [NREQ-1:0]   owner_onehot_s;
    logic [WIDTH-1:0]  count_inc_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_arb (
        .req        (req),
        .last_owner (last_owner_r),
        .winner     (win_s),
        .valid      (win_valid_s)
    );

    // Encode the one-hot winner and fetch its length slice.
    always_comb begin
        win_idx_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            win_idx_s = win_idx_s | (win_s[i] ? IDXW'(i) : '0);
        end
        win_len_s      = len[int'(win_idx_s)*WIDTH +: WIDTH];
        owner_req_s    = req[owner_r];
        owner_onehot_s = NREQ'(1) << owner_r;
        count_inc_s    = count_r + WIDTH'(1);
    end

    // Burst FSM; every output is registered here so it changes only on clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            owner_r      <= '0;
            last_owner_r <= IDXW'(NREQ - 1);
            len_r        <= '0;
            count_r      <= '0;
            gnt_r        <= '0;
            done_r       <= '0;
            abort_r      <= '0;
            busy_r       <= 1'b0;
        end else begin
            done_r  <= '0;
            abort_r <= '0;
            case (state_r)
                IDLE: begin
                    if (win_valid_s) begin
                        owner_r <= win_idx_s;
                        len_r   <= win_len_s;
                        gnt_r   <= win_s;
                        busy_r  <= 1'b1;
                        state_r <= CLEAR;
                    end else begin
                        gnt_r   <= '0;
                        busy_r  <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (!owner_req_s) begin
                        abort_r      <= owner_onehot_s;
                        gnt_r        <= '0;
                        last_owner_r <= owner_r;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end else begin
                        count_r <= '0;
                        state_r <= (len_r == '0) ? FINISH : RUN;
                    end
                end
                RUN: begin
                    // Withdrawal freezes count where it stands.
                    if (!owner_req_s) begin
                        abort_r      <= owner_onehot_s;
                        gnt_r        <= '0;
                        last_owner_r <= owner_r;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end else begin
                        count_r <= count_inc_s;
                        state_r <= (count_inc_s == len_r) ? FINISH : RUN;
                    end
                end
                FINISH: begin
                    done_r       <= owner_onehot_s;
                    last_owner_r <= owner_r;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    gnt_r   <= '0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign gnt   = gnt_r;
    assign count = count_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign abort = abort_r;

endmodule

// File: tb/tb_count_scheduler.sv
// Scenario bench for count_scheduler: per-feature tasks with a queue of
// expected done/abort events popped as the design reports them.
module tb_count_scheduler;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic                  clk   = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req   = '0;
    logic [NREQ*WIDTH-1:0] len   = '0;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic [NREQ-1:0]       done;
    logic [NREQ-1:0]       abort;

    typedef struct {
        logic [NREQ-1:0]  done_v;
        logic [NREQ-1:0]  abort_v;
        logic [WIDTH-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;

    count_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .count (count),
        .busy  (busy),
        .done  (done),
        .abort (abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset;
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_event(input int max_cycles, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if ((done | abort) != '0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clk);
        tests_run++;
        if ({gnt, count, busy, done, abort} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got gnt=%b count=%0d busy=%b done=%b abort=%b, expected all zero",
                     gnt, count, busy, done, abort);
        end
    endtask

    task automatic test_single;
        exp_t e;
        exp_q.delete();
        len[0 +: WIDTH] = 8'd3;
        req = 4'b0001;
        exp_q.push_back('{4'b0001, 4'b0000, 8'd3});
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) begin
                tests_run++;
                if (gnt !== 4'b0001 || busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL single_grant: got gnt=%b busy=%b, expected gnt=0001 busy=1", gnt, busy);
                end
            end
            if (c >= 2 && c <= 5) begin
                tests_run++;
                if (count !== WIDTH'(c - 2)) begin
                    tests_failed++;
                    $display("FAIL single_count_c%0d: got %0d expected %0d", c, count, c - 2);
                end
            end
            if (c == 6) begin
                e = exp_q.pop_front();
                tests_run++;
                if (done !== e.done_v || abort !== e.abort_v || count !== e.cnt) begin
                    tests_failed++;
                    $display("FAIL single_done: got done=%b abort=%b count=%0d expected done=%b abort=%b count=%0d",
                             done, abort, count, e.done_v, e.abort_v, e.cnt);
                end
                req = '0;
            end
            if (c == 7) begin
                tests_run++;
                if (gnt !== 4'b0000 || count !== 8'd3) begin
                    tests_failed++;
                    $display("FAIL single_release: got gnt=%b count=%0d expected gnt=0000 count=3", gnt, count);
                end
            end
        end
    endtask

    task automatic test_round_robin;
        exp_t e;
        bit   to;
        int   prev;
        exp_q.delete();
        do_reset();
        len = {4{8'd1}};
        req = 4'b1111;
        exp_q.push_back('{4'b0001, 4'b0000, 8'd1});
        exp_q.push_back('{4'b0010, 4'b0000, 8'd1});
        exp_q.push_back('{4'b0100, 4'b0000, 8'd1});
        exp_q.push_back('{4'b1000, 4'b0000, 8'd1});
        exp_q.push_back('{4'b0001, 4'b0000, 8'd1});
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_event(12, to);
            tests_run++;
            if (to) begin
                tests_failed++;
                $display("FAIL rr_timeout_%0d: no done within 12 cycles, expected done", k);
                break;
            end
            e = exp_q.pop_front();
            if (done !== e.done_v || abort !== e.abort_v || count !== e.cnt) begin
                tests_failed++;
                $display("FAIL rr_done_%0d: got done=%b abort=%b count=%0d expected done=%b abort=%b count=%0d",
                         k, done, abort, count, e.done_v, e.abort_v, e.cnt);
            end
            if (k > 0) begin
                tests_run++;
                if (cyc - prev != 4) begin
                    tests_failed++;
                    $display("FAIL rr_period_%0d: got %0d cycles expected 4", k, cyc - prev);
                end
            end
            prev = cyc;
            if (k == 4) req = '0;
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero_len;
        exp_t e;
        bit   to;
        int   start;
        exp_q.delete();
        len[WIDTH +: WIDTH] = 8'd0;
        req   = 4'b0010;
        start = cyc;
        exp_q.push_back('{4'b0010, 4'b0000, 8'd0});
        wait_event(6, to);
        tests_run++;
        if (to) begin
            tests_failed++;
            $display("FAIL zero_timeout: no done within 6 cycles, expected done");
        end else begin
            e = exp_q.pop_front();
            if (done !== e.done_v || abort !== e.abort_v || count !== e.cnt) begin
                tests_failed++;
                $display("FAIL zero_done: got done=%b abort=%b count=%0d expected done=%b abort=%b count=%0d",
                         done, abort, count, e.done_v, e.abort_v, e.cnt);
            end
            tests_run++;
            if (cyc - start != 3) begin
                tests_failed++;
                $display("FAIL zero_latency: got %0d cycles expected 3", cyc - start);
            end
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort;
        exp_t e;
        bit   to;
        bit   found;
        bit   early;
        exp_q.delete();
        do_reset();
        len[2*WIDTH +: WIDTH] = 8'd10;
        len[3*WIDTH +: WIDTH] = 8'd2;
        req   = 4'b1100;
        found = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((done | abort) != '0) early = 1'b1;
            if (count == 8'd4 && gnt == 4'b0100) begin
                found = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!found || early) begin
            tests_failed++;
            $display("FAIL abort_setup: got found=%b early_pulse=%b expected found=1 early_pulse=0", found, early);
        end
        req = 4'b1000;
        exp_q.push_back('{4'b0000, 4'b0100, 8'd4});
        @(negedge clk);
        e = exp_q.pop_front();
        tests_run++;
        if (done !== e.done_v || abort !== e.abort_v || count !== e.cnt || gnt !== 4'b0000) begin
            tests_failed++;
            $display("FAIL abort_pulse: got done=%b abort=%b count=%0d gnt=%b expected done=%b abort=%b count=%0d gnt=0000",
                     done, abort, count, gnt, e.done_v, e.abort_v, e.cnt);
        end
        @(negedge clk);
        tests_run++;
        if (gnt !== 4'b1000) begin
            tests_failed++;
            $display("FAIL abort_next_grant: got %b expected 1000", gnt);
        end
        exp_q.push_back('{4'b1000, 4'b0000, 8'd2});
        wait_event(8, to);
        tests_run++;
        if (to) begin
            tests_failed++;
            $display("FAIL abort_followup_timeout: no done within 8 cycles, expected done");
        end else begin
            e = exp_q.pop_front();
            if (done !== e.done_v || abort !== e.abort_v || count !== e.cnt) begin
                tests_failed++;
                $display("FAIL abort_followup: got done=%b abort=%b count=%0d expected done=%b abort=%b count=%0d",
                         done, abort, count, e.done_v, e.abort_v, e.cnt);
            end
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit found;
        bit pulse;
        len[0 +: WIDTH] = 8'd20;
        req   = 4'b0001;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (count == 8'd5 && gnt == 4'b0001) begin
                found = 1'b1;
                break;
            end
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (!found || {gnt, count, busy, done, abort} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_state: got found=%b gnt=%b count=%0d busy=%b done=%b abort=%b expected found=1 and all zero",
                     found, gnt, count, busy, done, abort);
        end
        reset = 1'b0;
        req   = '0;
        pulse = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if ((done | abort) != '0 || busy) pulse = 1'b1;
        end
        tests_run++;
        if (pulse) begin
            tests_failed++;
            $display("FAIL midreset_quiet: got pulse or busy after reset, expected none");
        end
    endtask

    task automatic test_max_len;
        exp_t        e;
        bit          to;
        bit          wrapped;
        logic [7:0]  prev;
        exp_q.delete();
        len[0 +: WIDTH] = 8'd255;
        req     = 4'b0001;
        wrapped = 1'b0;
        prev    = 8'd0;
        exp_q.push_back('{4'b0001, 4'b0000, 8'd255});
        to = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy && count < prev) wrapped = 1'b1;
            if (busy) prev = count;
            if ((done | abort) != '0) begin
                to = 1'b0;
                break;
            end
        end
        tests_run++;
        if (to || wrapped) begin
            tests_failed++;
            $display("FAIL maxlen_run: got timeout=%b wrapped=%b expected both 0", to, wrapped);
        end else begin
            e = exp_q.pop_front();
            tests_run++;
            if (done !== e.done_v || abort !== e.abort_v || count !== e.cnt) begin
                tests_failed++;
                $display("FAIL maxlen_done: got done=%b abort=%b count=%0d expected done=%b abort=%b count=%0d",
                         done, abort, count, e.done_v, e.abort_v, e.cnt);
            end
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_len();
        test_abort();
        test_reset_mid();
        test_max_len();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
